// File: rtl/tt_btn_conditioner.sv
// Six-button front-end: 2-flop sync, per-bit debounce, per-pair press/hold/auto-repeat FSM.
// First pulse 2+DEBOUNCE_CYCLES+1 cycles after a clean press; registered 1-cycle pulses, no backpressure.
module tt_btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES     = 500000,
  parameter int REPEAT_CYCLES   = 100000
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [5:0] btn_i,
  input  logic       repeat_en_i,
  output logic [1:0] hour_id_o,
  output logic [1:0] minute_id_o,
  output logic [1:0] seconds_id_o
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  logic [5:0]    sync1_q, sync2_q;
  logic [5:0]    db_q, db_d;
  logic [DW-1:0] cnt_q [6];
  logic [DW-1:0] cnt_d [6];
  logic [5:0]    pair_id;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // A mismatch must persist DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    db_d = db_q;
    for (int b = 0; b < 6; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != db_q[b]) begin
        if (cnt_q[b] == DB_LAST) db_d[b] = sync2_q[b];
        else                     cnt_d[b] = cnt_q[b] + DW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      db_q <= '0;
      for (int b = 0; b < 6; b++) cnt_q[b] <= '0;
    end else begin
      db_q <= db_d;
      for (int b = 0; b < 6; b++) cnt_q[b] <= cnt_d[b];
    end
  end

  for (genvar g = 0; g < 3; g++) begin : gen_pair
    state_t        state_q, state_d;
    logic          dir_q, dir_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0]    pat, dir_pat, pulse_d, id_q;
    logic          single, match;

    assign pat     = db_q[2*g +: 2];
    assign single  = (pat == 2'b10) || (pat == 2'b01);
    assign dir_pat = dir_q ? 2'b10 : 2'b01;
    assign match   = (pat == dir_pat);

    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        state_q <= S_IDLE;
        dir_q   <= 1'b0;
        tmr_q   <= '0;
      end else begin
        state_q <= state_d;
        dir_q   <= dir_d;
        tmr_q   <= tmr_d;
      end
    end

    always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      tmr_d   = tmr_q;
      unique case (state_q)
        S_IDLE: begin
          if (single) begin
            dir_d   = pat[1];
            tmr_d   = '0;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!match)              state_d = S_IDLE;
          else if (!repeat_en_i)   tmr_d   = '0;
          else if (tmr_q == HOLD_LAST) begin
            tmr_d   = '0;
            state_d = S_REPEAT;
          end else                 tmr_d   = tmr_q + TW'(1);
        end
        S_REPEAT: begin
          if (!match)              state_d = S_IDLE;
          else if (!repeat_en_i) begin
            tmr_d   = '0;
            state_d = S_HOLD;
          end else if (tmr_q == REP_LAST) tmr_d = '0;
          else                     tmr_d   = tmr_q + TW'(1);
        end
        default:                   state_d = S_IDLE;
      endcase
    end

    always_comb begin
      pulse_d = 2'b00;
      unique case (state_q)
        S_IDLE:   if (single) pulse_d = pat;
        S_HOLD:   if (match && repeat_en_i && tmr_q == HOLD_LAST) pulse_d = dir_pat;
        S_REPEAT: if (match && repeat_en_i && tmr_q == REP_LAST)  pulse_d = dir_pat;
        default:  pulse_d = 2'b00;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (!rstn_i) id_q <= 2'b00;
      else         id_q <= pulse_d;
    end

    assign pair_id[2*g +: 2] = id_q;
  end

  assign seconds_id_o = pair_id[1:0];
  assign minute_id_o  = pair_id[3:2];
  assign hour_id_o    = pair_id[5:4];

endmodule

// File: tb/tb_tt_btn_conditioner.sv
// Directed bench for tt_btn_conditioner with DEBOUNCE=4, HOLD=20, REPEAT=8.
// Step i means inputs applied before rising edge i of the scenario; outputs sampled 1ns after that edge.
module tb_tt_btn_conditioner;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] btn;
  logic       repeat_en;
  logic [1:0] hour_id, minute_id, seconds_id;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  tt_btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .btn_i       (btn),
    .repeat_en_i (repeat_en),
    .hour_id_o   (hour_id),
    .minute_id_o (minute_id),
    .seconds_id_o(seconds_id)
  );

  task automatic chk(input string tag, input int i, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s step=%0d observed=%b expected=%b", tag, i, obs, exp);
    end
  endtask

  task automatic step(input string sc, input int i,
                      input logic [1:0] eh, input logic [1:0] em, input logic [1:0] es);
    @(posedge clk);
    #1;
    chk({sc, "_hour"}, i, hour_id, eh);
    chk({sc, "_min"},  i, minute_id, em);
    chk({sc, "_sec"},  i, seconds_id, es);
  endtask

  initial begin
    rstn      = 1'b0;
    btn       = 6'b000000;
    repeat_en = 1'b1;

    // Reset: outputs zero from the first edge.
    step("rst", 1, 2'b00, 2'b00, 2'b00);
    step("rst", 2, 2'b00, 2'b00, 2'b00);
    rstn = 1'b1;

    // 1: hour inc held 10 cycles -> single pulse at step 7.
    btn = 6'b100000;
    for (int i = 1; i <= 25; i++) begin
      if (i == 11) btn = 6'b000000;
      step("s1", i, (i == 7) ? 2'b10 : 2'b00, 2'b00, 2'b00);
    end

    // 2: minute dec held 60 cycles -> 7, 27, then every 8 up to 59.
    btn = 6'b000100;
    for (int i = 1; i <= 80; i++) begin
      if (i == 61) btn = 6'b000000;
      step("s2", i, 2'b00,
           (i == 7 || (i >= 27 && i <= 59 && (i - 27) % 8 == 0)) ? 2'b01 : 2'b00,
           2'b00);
    end

    // 3: glitchy seconds dec never debounces.
    for (int i = 1; i <= 25; i++) begin
      btn = (i <= 3 || (i >= 5 && i <= 7)) ? 6'b000001 : 6'b000000;
      step("s3", i, 2'b00, 2'b00, 2'b00);
    end

    // 4: both seconds bits held, then dec dropped -> inc press at 47, repeats 67,75,83,91.
    btn = 6'b000011;
    for (int i = 1; i <= 110; i++) begin
      if (i == 41) btn = 6'b000010;
      if (i == 91) btn = 6'b000000;
      step("s4", i, 2'b00, 2'b00,
           (i == 47 || (i >= 67 && i <= 91 && (i - 67) % 8 == 0)) ? 2'b10 : 2'b00);
    end

    // 5: repeat disabled -> one hour dec pulse; enabling at 101 -> 120, then 128.
    repeat_en = 1'b0;
    btn       = 6'b010000;
    for (int i = 1; i <= 145; i++) begin
      if (i == 101) repeat_en = 1'b1;
      if (i == 125) btn = 6'b000000;
      step("s5", i, (i == 7 || i == 120 || i == 128) ? 2'b01 : 2'b00, 2'b00, 2'b00);
    end

    // 6: reset mid-press discards it; minute inc and hour inc re-debounce and pulse together.
    btn = 6'b001000;
    for (int i = 1; i <= 35; i++) begin
      if (i == 8) begin
        rstn = 1'b0;
        btn  = 6'b101000;
      end
      if (i == 10) rstn = 1'b1;
      if (i == 21) btn = 6'b000000;
      step("s6", i, (i == 16) ? 2'b10 : 2'b00,
           (i == 7 || i == 16) ? 2'b10 : 2'b00, 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
